// File: rtl/sub_bytes_serial.sv
// Iterative AES SubBytes: substitutes LANES bytes per cycle in a 16-byte working register.
// Define SUB_BYTES_SHIFTROWS_EN to present ShiftRows(SubBytes(state)) on out_state.
module sub_bytes_serial #(
    parameter int LANES = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int         GROUPS = 16 / LANES;
    localparam logic [3:0] LAST   = 4'(GROUPS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     state;
    logic [3:0] cnt;
    logic [7:0] work [16];
    logic [3:0] idx  [LANES];
    logic [7:0] sub  [LANES];

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] s;
        s = 8'h00;
        case (b)
            8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
            8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
            8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
            8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
            8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
            8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
            8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
            8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
            8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
            8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
            8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
            8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
            8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
            8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
            8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
            8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
            8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
            8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
            8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
            8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
            8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
            8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
            8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
            8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
            8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
            8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
            8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
            8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
            8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
            8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
            8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
            8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
        endcase
        return s;
    endfunction

    // Lane l works on byte cnt*LANES+l; cnt never passes LAST so the index stays in range.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            idx[l] = 4'(int'(cnt) * LANES + l);
            sub[l] = sbox(work[idx[l]]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            for (int i = 0; i < 16; i++) work[i] <= 8'h00;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    for (int i = 0; i < 16; i++) work[i] <= in_state[127 - 8*i -: 8];
                    cnt   <= 4'd0;
                    state <= RUN;
                end
                RUN: begin
                    for (int l = 0; l < LANES; l++) work[idx[l]] <= sub[l];
                    if (cnt == LAST) state <= DONE;
                    else             cnt   <= cnt + 4'd1;
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_comb begin
        out_state = '0;
        for (int i = 0; i < 16; i++) begin
`ifdef SUB_BYTES_SHIFTROWS_EN
            // row r = i%4, column c = i/4 takes the byte from column (c+r)%4 of the same row
            out_state[127 - 8*i -: 8] = work[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)];
`else
            out_state[127 - 8*i -: 8] = work[i];
`endif
        end
    end

endmodule

// File: tb/tb_sub_bytes_serial.sv
// Scoreboard bench for sub_bytes_serial; S-box reference is derived from GF(2^8) arithmetic.
module tb_sub_bytes_serial;
    parameter int LANES = 1;
    localparam int G = 16 / LANES;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    sub_bytes_serial #(.LANES(LANES)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
        .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int last_acc = 0;
    int last_hs  = 0;
    logic prev_ov = 1'b0;
    logic [7:0]   tbl [256];
    logic [127:0] sb [$];
    int           accq [$];

`ifdef SUB_BYTES_SHIFTROWS_EN
    localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
`else
    localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
`endif
    localparam logic [127:0] FIPS_IN = 128'h193de3bea0f4e22b9ac68d2ae9f84808;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s);
        logic [7:0]   sub [16];
        logic [127:0] r;
        for (int i = 0; i < 16; i++) sub[i] = tbl[s[127 - 8*i -: 8]];
        for (int i = 0; i < 16; i++) begin
`ifdef SUB_BYTES_SHIFTROWS_EN
            r[127 - 8*i -: 8] = sub[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)];
`else
            r[127 - 8*i -: 8] = sub[i];
`endif
        end
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Handshakes seen at the falling edge complete on the following rising edge (cyc+1).
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            accq.delete();
            prev_ov = 1'b0;
        end else begin
            if (out_valid && !prev_ov) begin
                if (accq.size() == 0) check("spurious_out_valid", 128'(out_valid), 128'd0);
                else                  check("latency", 128'(cyc - accq[0]), 128'(G));
            end
            if (out_valid && out_ready) begin
                last_hs = cyc + 1;
                if (sb.size() == 0) check("unexpected_output", out_state, 128'hx);
                else begin
                    check("data", out_state, sb.pop_front());
                    void'(accq.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                last_acc = cyc + 1;
                sb.push_back(model(in_state));
                accq.push_back(cyc + 1);
            end
            prev_ov = out_valid;
        end
    end

    task automatic wait_accept(input int budget);
        bit got = 0;
        for (int k = 0; k < budget && !got; k++) begin
            @(negedge clk);
            if (in_valid && in_ready) got = 1;
        end
        if (!got) check("accept_timeout", 128'd0, 128'd1);
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [127:0] s);
        in_state = s;
        in_valid = 1'b1;
        wait_accept(G + 10);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        bit done = 0;
        for (int k = 0; k < budget && !done; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) done = 1;
        end
        if (!done) check("drain_timeout", 128'(sb.size()), 128'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] inv;
        tbl[0] = 8'h63;
        for (int x = 1; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            tbl[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_state = '0;
        @(negedge clk);
        check("rst_in_ready", 128'(in_ready), 128'd0);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_out_state", out_state, 128'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 128'(in_ready), 128'd1);
        @(posedge clk); #1;

        out_ready = 1'b1;
        send(128'h0);
        wait_drain(G + 10);
        send(FIPS_IN);
        wait_drain(G + 10);

        // Stall in DONE while upstream wiggles its inputs.
        out_ready = 1'b0;
        send(FIPS_IN);
        for (int k = 0; k < G + 5 && !out_valid; k++) @(negedge clk);
        check("stall_reach_done", 128'(out_valid), 128'd1);
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            in_state = {$urandom, $urandom, $urandom, $urandom};
            in_valid = 1'(k % 2);
            @(negedge clk);
            check("stall_out_valid", 128'(out_valid), 128'd1);
            check("stall_out_state", out_state, FIPS_OUT);
            check("stall_in_ready", 128'(in_ready), 128'd0);
            check("stall_busy", 128'(busy), 128'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_drain(G + 10);

        // Abort a transfer seven cycles after acceptance.
        out_ready = 1'b0;
        send({16{8'h53}});
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("abort_out_valid", 128'(out_valid), 128'd0);
        check("abort_out_state", out_state, 128'd0);
        check("abort_busy", 128'(busy), 128'd0);
        @(posedge clk); #1 rst = 1'b0;
        out_ready = 1'b1;
        repeat (G + 2) begin
            @(negedge clk);
            check("abort_no_result", 128'(out_valid), 128'd0);
        end
        @(posedge clk); #1;
        send({16{8'h53}});
        for (int k = 0; k < G + 5 && !out_valid; k++) @(negedge clk);
        check("fresh_53", out_state, model({16{8'h53}}));
        wait_drain(G + 10);

        // Back-to-back with in_valid held high.
        in_state = FIPS_IN;
        in_valid = 1'b1;
        wait_accept(G + 10);
        in_state = 128'h00112233445566778899aabbccddeeff;
        wait_accept(G + 10);
        in_valid = 1'b0;
        check("b2b_gap", 128'(last_acc - last_hs), 128'd1);
        wait_drain(G + 10);

        for (int k = 0; k < 4; k++) begin
            send({$urandom, $urandom, $urandom, $urandom});
            wait_drain(G + 10);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/sub_bytes_serial.md
SUB_BYTES_SERIAL -- requirements
Module: sub_bytes_serial

Interface
REQ-001 Parameter LANES, default 1, meaning: number of forward S-box instances (bytes substituted per cycle); legal values 1, 2, 4, 8, 16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  upstream presents a 128-bit AES state.
REQ-005 in_ready  output  1  block can accept a state.
REQ-006 in_state  input  128  input state; byte 0 = bits [127:120], byte 15 = bits [7:0].
REQ-007 out_valid  output  1  out_state holds a completed result.
REQ-008 out_ready  input  1  downstream accepts result.
REQ-009 out_state  output  128  transformed state, same byte order as in_state.
REQ-010 busy  output  1  high in RUN and DONE.

Function
REQ-011 Each byte SHALL be mapped through the FIPS-197 forward S-box (SubBytes), the exact inverse of the FIPS-197 inverse S-box; the table SHALL be a combinational case-based lookup.
REQ-012 FSM states: IDLE, RUN, DONE; encoding free.
REQ-013 IDLE: in_ready=1; on in_valid&in_ready, capture in_state into a working register, clear byte counter, go to RUN.
REQ-014 RUN: each cycle, substitute LANES consecutive bytes starting at index cnt*LANES in place; cnt increments by 1.
REQ-015 RUN exits to DONE on the cycle processing the last group (cnt = 16/LANES-1); counter width SHALL be 4 bits, with no wrap past the last group.
REQ-016 DONE: out_valid=1; out_state driven from working register and stable until handshake; on out_ready go to IDLE.
REQ-017 Latency: acceptance edge N -> out_valid high from edge N+16/LANES (16 cycles for LANES=1, 1 cycle for LANES=16).
REQ-018 in_ready SHALL be 0 in RUN and DONE; in_valid and in_state changes there SHALL be ignored.
REQ-019 A new state SHALL NOT be accepted in the same cycle as the output handshake; earliest next acceptance is the cycle after returning to IDLE (throughput one state per 16/LANES+2 cycles).
REQ-020 out_ready while not in DONE SHALL have no effect.
REQ-021 Captured input SHALL NOT depend on in_state after the acceptance edge.

Reset
REQ-022 rst high SHALL immediately force state IDLE, counter 0, working register 0.
REQ-023 Reset values: in_ready=1 after rst deasserts (0 while rst high), out_valid=0, busy=0, out_state=128'h0.
REQ-024 rst asserted in RUN or DONE SHALL abort the operation; no result SHALL be presented afterwards.

Configuration
REQ-025 Macro SUB_BYTES_SHIFTROWS_EN: when defined, out_state SHALL be ShiftRows(SubBytes(in_state)), combinationally permuted from the working register, with row r = index mod 4, column c = index div 4, out[r][c] = sub[r][(c+r) mod 4]; latency unchanged.
REQ-026 When SUB_BYTES_SHIFTROWS_EN is undefined, out_state SHALL be SubBytes(in_state) only, with no permutation logic.

Verification
REQ-027 LANES=1, in_state=128'h0 -> after 16 cycles out_state=128'h6363...63 (all 16 bytes 0x63), out_valid=1.
REQ-028 in_state=193de3bea0f4e22b9ac68d2ae9f84808 -> out_state=d42711aee0bf98f1b8b45de51e415230 (macro undefined); with macro, d4bf5d30e0b452aeb84111f11e2798e5.
REQ-029 Hold out_ready=0 for 5 cycles in DONE -> out_valid and out_state stable; in_ready=0; toggling in_state has no effect.
REQ-030 Assert rst at RUN cycle 7 with in_state=all 0x53 -> out_valid=0, out_state=0, state IDLE; a fresh all-0x53 transfer afterwards yields all 0xed.
REQ-031 Back-to-back: in_valid held high with two states, out_ready=1 -> second acceptance exactly one cycle after first output handshake; both results correct.
REQ-032 Repeat REQ-027/028 for LANES=2,4,8,16 -> identical results, latency 8/4/2/1 cycles.
